// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Handles load-use hazards, taken-branch flushes and data-memory waits, and keeps perf counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_UsesRt,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic                  EX_BranchTaken,
  input  logic                  EX_MEM_MemAcc,
  input  logic                  DMemReady,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Write,
  output logic                  ID_EX_Bubble,
  output logic                  EX_MEM_Write,
  output logic                  MEM_WB_Bubble,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount,
  output logic                  MemTimeoutErr
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_stall, load_use;
  logic              stall_inc, flush_inc, err_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    mem_stall = (state != ERROR) && EX_MEM_MemAcc && !DMemReady;
    load_use  = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    err_set       = 1'b0;

    if (state == ERROR || mem_stall) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
      if (mem_stall) begin
        stall_inc = 1'b1;
        // Reaching the limit on this stall cycle means MEM_TIMEOUT consecutive waits.
        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = ERROR;
          err_set   = 1'b1;
        end else begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
    end else begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
      if (EX_BranchTaken) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        stall_inc    = 1'b1;
      end
    end

    // While reset is held the pipeline registers must see a neutral, free-running control set.
    if (!Reset_n) begin
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Write   = 1'b1;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Write  = 1'b1;
      MEM_WB_Bubble = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      StallCount    <= '0;
      FlushCount    <= '0;
      MemTimeoutErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_inc) StallCount <= sat_inc(StallCount);
      if (flush_inc) FlushCount <= sat_inc(FlushCount);
      if (err_set)   MemTimeoutErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a main instance with a short memory timeout
// and a second instance with 2-bit counters sharing the same stimulus.
module tb_pipeline_hazard_controller;

  localparam logic [6:0] NORMAL  = 7'b1101010;
  localparam logic [6:0] LOADUSE = 7'b0001110;
  localparam logic [6:0] BRANCH  = 7'b1111110;
  localparam logic [6:0] FROZEN  = 7'b0000001;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic       IF_ID_UsesRt, ID_EX_MemRead, EX_BranchTaken, EX_MEM_MemAcc, DMemReady;

  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble;
  logic [15:0] StallCount, FlushCount;
  logic        MemTimeoutErr;

  logic       s_pc, s_ifw, s_ifl, s_idw, s_idb, s_exw, s_mwb;
  logic [1:0] s_stall, s_flush;
  logic       s_err;

  logic [6:0] ctl, s_ctl;
  assign ctl   = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble};
  assign s_ctl = {s_pc, s_ifw, s_ifl, s_idw, s_idb, s_exw, s_mwb};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  pipeline_hazard_controller #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt), .EX_BranchTaken(EX_BranchTaken),
    .EX_MEM_MemAcc(EX_MEM_MemAcc), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Write(EX_MEM_Write),
    .MEM_WB_Bubble(MEM_WB_Bubble), .StallCount(StallCount), .FlushCount(FlushCount),
    .MemTimeoutErr(MemTimeoutErr)
  );

  pipeline_hazard_controller #(.REG_ADDR_W(5), .MEM_TIMEOUT(64), .CNT_W(2)) dut_s (
    .Clock(Clock), .Reset_n(Reset_n),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt), .EX_BranchTaken(EX_BranchTaken),
    .EX_MEM_MemAcc(EX_MEM_MemAcc), .DMemReady(DMemReady),
    .PCWrite(s_pc), .IF_ID_Write(s_ifw), .IF_ID_Flush(s_ifl),
    .ID_EX_Write(s_idw), .ID_EX_Bubble(s_idb), .EX_MEM_Write(s_exw),
    .MEM_WB_Bubble(s_mwb), .StallCount(s_stall), .FlushCount(s_flush),
    .MemTimeoutErr(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs then change away from the edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    IF_ID_Rs = '0; IF_ID_Rt = '0; IF_ID_UsesRt = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_Rt = '0;
    EX_BranchTaken = 1'b0; EX_MEM_MemAcc = 1'b0; DMemReady = 1'b1;
  endtask

  initial begin
    idle();
    Reset_n = 1'b0;
    #2;
    chk("rst_ctl", ctl, NORMAL);
    chk("rst_stall", StallCount, 0);
    chk("rst_flush", FlushCount, 0);
    chk("rst_err", MemTimeoutErr, 0);
    cyc(); cyc();
    Reset_n = 1'b1;
    #1;
    chk("run_idle", ctl, NORMAL);

    // T1 load-use on Rs, one bubble then released
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
    #1 chk("t1_stall", ctl, LOADUSE);
    cyc();
    ID_EX_MemRead = 1'b0;
    #1 chk("t1_release", ctl, NORMAL);
    chk("t1_cnt", StallCount, 1);

    // T2 r0 destination and unused Rt never stall; used Rt does
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
    #1 chk("t2_r0", ctl, NORMAL);
    ID_EX_Rt = 5'd7; IF_ID_Rt = 5'd7; IF_ID_Rs = 5'd3; IF_ID_UsesRt = 1'b0;
    #1 chk("t2_rt_unused", ctl, NORMAL);
    IF_ID_UsesRt = 1'b1;
    #1 chk("t2_rt_used", ctl, LOADUSE);
    cyc();
    ID_EX_MemRead = 1'b0;
    #1 chk("t2_cnt", StallCount, 2);

    // T3 branch overrides simultaneous load-use
    idle();
    EX_BranchTaken = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
    #1 chk("t3_ctl", ctl, BRANCH);
    cyc();
    idle();
    #1 chk("t3_flush", FlushCount, 1);
    chk("t3_stall", StallCount, 2);

    // T4 three wait cycles with a branch held, then branch acted on after release
    EX_MEM_MemAcc = 1'b1; DMemReady = 1'b0; EX_BranchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4_frozen%0d", i), ctl, FROZEN);
      cyc();
    end
    DMemReady = 1'b1;
    #1 chk("t4_branch_after", ctl, BRANCH);
    chk("t4_stall", StallCount, 5);
    chk("t4_noerr", MemTimeoutErr, 0);
    cyc();
    idle();
    #1 chk("t4_flush", FlushCount, 2);
    chk("t4_run", ctl, NORMAL);

    // T5 timeout after four consecutive waits, then async reset mid-cycle
    EX_MEM_MemAcc = 1'b1; DMemReady = 1'b0;
    cyc(); cyc(); cyc();
    #1 chk("t5_err_before", MemTimeoutErr, 0);
    cyc();
    #1 chk("t5_err_set", MemTimeoutErr, 1);
    EX_MEM_MemAcc = 1'b0; DMemReady = 1'b1;
    #1 chk("t5_err_frozen", ctl, FROZEN);
    cyc();
    #1 chk("t5_err_sticky", MemTimeoutErr, 1);
    chk("t5_stall", StallCount, 9);
    chk("t5_still_frozen", ctl, FROZEN);
    Reset_n = 1'b0;
    #1 chk("t5_rst_err", MemTimeoutErr, 0);
    chk("t5_rst_stall", StallCount, 0);
    chk("t5_rst_ctl", ctl, NORMAL);
    #1 Reset_n = 1'b1;
    #1 chk("t5_run", ctl, NORMAL);

    // T6 five load-use stalls saturate the 2-bit counter
    cyc();
    for (int i = 0; i < 5; i++) begin
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
      #1 if (i == 0) chk("t6_ctl", s_ctl, LOADUSE);
      cyc();
      ID_EX_MemRead = 1'b0;
      cyc();
    end
    chk("t6_sat", s_stall, 3);
    chk("t6_wide", StallCount, 5);
    chk("t6_flush", s_flush, 0);
    chk("t6_err", s_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
